// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//   Multi-channel reset sequencer for the KC705 OV7670 design. Combines the
//   external reset, PLL lock and a software reset request into one request.
//   While a request is present, every channel is held in reset. Once the
//   request clears, the channels are released one at a time in a fixed order
//   (bit 0 first), for example clocking -> SCCB -> capture -> VGA. Any new
//   request restarts the whole sequence from a full hold period.
//
// Parameters
//   NUM_CH        number of active-high reset outputs (>=1)
//   HOLD_CYCLES   edges from the first request-free cycle to channel 0 release
//   STAGE_CYCLES  edges between consecutive channel releases
//   LOCK_FILTER   consecutive synced pll_locked=1 cycles needed for lock_ok
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ext_reset    asynchronous active-high reset request (2-FF synchronised)
//   pll_locked   asynchronous PLL lock (2-FF synchronised, then filtered)
//   sw_reset     synchronous active-high request, a 1-cycle pulse suffices
//   reset_out    active-high channel resets, bit 0 released first
//   seq_done     high once every channel is released
//
// Build option
//   RESET_SEQ_CAUSE_EN  when defined, adds
//     reset_cause [2:0] = {sw, lock, ext} sources of the current/last episode
//     reset_count [7:0] saturating count of re-entries into ASSERT
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module reset_sequencer #(
    parameter int NUM_CH       = 4,
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_CYCLES = 8,
    parameter int LOCK_FILTER  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ext_reset,
    input  logic              pll_locked,
    input  logic              sw_reset,
    output logic [NUM_CH-1:0] reset_out,
    output logic              seq_done
`ifdef RESET_SEQ_CAUSE_EN
    ,
    output logic [2:0]        reset_cause,
    output logic [7:0]        reset_count
`endif
);

    localparam int MAX_HS  = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
    localparam int MAX_ALL = (MAX_HS > LOCK_FILTER) ? MAX_HS : LOCK_FILTER;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    // HOLD is entered one edge after T0, so its terminal count is two short
    // of HOLD_CYCLES. HOLD_CYCLES=1 never enters HOLD at all.
    localparam int HOLD_LAST_I = (HOLD_CYCLES >= 2) ? HOLD_CYCLES - 2 : 0;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_LAST_I);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_FILTER - 1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_STAGE,
        ST_RUN
    } state_e;

    // ---------------------------------------------------------------------
    // Input synchronisers
    // ---------------------------------------------------------------------
    logic ext_meta_q, ext_sync_q;
    logic lock_meta_q, lock_sync_q;

    // NOTE: the reset branch sits in the sensitivity list so the flops clear
    // without a clock; every sequential assignment is non-blocking so all
    // flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_meta_q  <= 1'b1;   // external reset assumed active until proven otherwise
            ext_sync_q  <= 1'b1;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            ext_meta_q  <= ext_reset;
            ext_sync_q  <= ext_meta_q;
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    // ---------------------------------------------------------------------
    // Lock filter
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             lock_ok_q, lock_ok_d;
    logic             lock_ok;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        lock_ok_d  = lock_ok_q;
        if (!lock_sync_q) begin
            lock_cnt_d = '0;
            lock_ok_d  = 1'b0;
        end else if (!lock_ok_q) begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
            if (lock_cnt_q == LOCK_LAST) begin
                lock_ok_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            lock_ok_q  <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_ok_q  <= lock_ok_d;
        end
    end

    // Gating with the synced level drops lock_ok in the very first cycle the
    // lock is lost, rather than one edge later.
    assign lock_ok = lock_ok_q & lock_sync_q;

    logic req;
    assign req = ext_sync_q | ~lock_ok | sw_reset;

    // ---------------------------------------------------------------------
    // Sequencing FSM
    // ---------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0] reset_out_q, reset_out_d;
    logic             seq_done_q, seq_done_d;
    logic             do_release;

`ifdef RESET_SEQ_CAUSE_EN
    logic [2:0] cause_q, cause_d;
    logic [7:0] count_q, count_d;
    logic [2:0] src;
    assign src = {sw_reset, ~lock_ok, ext_sync_q};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        reset_out_d = reset_out_q;
        seq_done_d  = seq_done_q;
        do_release  = 1'b0;
`ifdef RESET_SEQ_CAUSE_EN
        cause_d     = cause_q;
        count_d     = count_q;
`endif

        if (req) begin
            state_d     = ST_ASSERT;
            cnt_d       = '0;
            reset_out_d = '1;
            seq_done_d  = 1'b0;
`ifdef RESET_SEQ_CAUSE_EN
            if (state_q != ST_ASSERT) begin
                // A fresh episode: remember only what triggered it.
                cause_d = src;
                if (count_q != 8'hFF) begin
                    count_d = count_q + 8'd1;
                end
            end else begin
                cause_d = cause_q | src;
            end
`endif
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (HOLD_CYCLES == 1) begin
                        do_release = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        do_release = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STAGE: begin
                    if (cnt_q == STAGE_LAST) begin
                        do_release = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;  // ST_RUN holds until the next request
            endcase

            if (do_release) begin
                // Shifting a zero in from the bottom releases the lowest
                // still-asserted channel and keeps the vector a thermometer.
                reset_out_d = reset_out_q << 1;
                cnt_d       = '0;
                if (reset_out_d == '0) begin
                    state_d    = ST_RUN;
                    seq_done_d = 1'b1;
                end else begin
                    state_d = ST_STAGE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= '0;
            reset_out_q <= '1;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reset_out_q <= reset_out_d;
            seq_done_q  <= seq_done_d;
        end
    end

    assign reset_out = reset_out_q;
    assign seq_done  = seq_done_q;

`ifdef RESET_SEQ_CAUSE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_q <= 3'b010;   // lock is never ok straight out of reset
            count_q <= 8'd0;
        end else begin
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    assign reset_cause = cause_q;
    assign reset_count = count_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
//   Directed bench for reset_sequencer with default parameters. Inputs are
//   driven on the falling clock edge and outputs sampled there, half a cycle
//   after the rising edge that updates them. Edge numbers in the comments
//   (P1, P2, ...) count rising edges after the stimulus point of each step.
//   The cause/count outputs are checked only when RESET_SEQ_CAUSE_EN is set.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_reset_sequencer;

    localparam int NUM_CH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ext_reset;
    logic              pll_locked;
    logic              sw_reset;
    logic [NUM_CH-1:0] reset_out;
    logic              seq_done;
`ifdef RESET_SEQ_CAUSE_EN
    logic [2:0]        reset_cause;
    logic [7:0]        reset_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_CH      (NUM_CH),
        .HOLD_CYCLES (16),
        .STAGE_CYCLES(8),
        .LOCK_FILTER (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ext_reset  (ext_reset),
        .pll_locked (pll_locked),
        .sw_reset   (sw_reset),
        .reset_out  (reset_out),
        .seq_done   (seq_done)
`ifdef RESET_SEQ_CAUSE_EN
        ,
        .reset_cause(reset_cause),
        .reset_count(reset_count)
`endif
    );

    // Thermometer invariant: the asserted bits must be a contiguous block at
    // the top, i.e. the inverted vector is of the form 0..01..1.
    logic [NUM_CH-1:0] thermo_inv;
    logic [NUM_CH-1:0] thermo_chk;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            thermo_inv = ~reset_out;
            thermo_chk = (thermo_inv + 4'd1) & thermo_inv;
            checks++;
            if (thermo_chk !== 4'b0000) begin
                $display("FAIL thermometer t=%0t reset_out=%b not a thermometer code", $time, reset_out);
                errors++;
            end
        end
    end

    // Advance n rising edges and land on the following falling edge.
    task automatic advance(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        ext_reset  = 1'b0;
        pll_locked = 1'b1;
        sw_reset   = 1'b0;
        @(negedge clk);
        advance(3);
        checks++;
        if (reset_out !== 4'b1111) begin
            $display("FAIL reset_out_in_reset got=%b exp=1111", reset_out);
            errors++;
        end
        checks++;
        if (seq_done !== 1'b0) begin
            $display("FAIL seq_done_in_reset got=%b exp=0", seq_done);
            errors++;
        end
`ifdef RESET_SEQ_CAUSE_EN
        checks++;
        if (reset_cause !== 3'b010) begin
            $display("FAIL cause_in_reset got=%b exp=010", reset_cause);
            errors++;
        end
        checks++;
        if (reset_count !== 8'd0) begin
            $display("FAIL count_in_reset got=%0d exp=0", reset_count);
            errors++;
        end
`endif
    endtask

    // lock_ok at P6, T0 = cycle after P6, releases at P22/P30/P38/P46.
    task automatic test_power_up();
        rst_n = 1'b1;
        advance(21);
        checks++;
        if (reset_out !== 4'b1111) begin
            $display("FAIL pwr_p21 got=%b exp=1111", reset_out);
            errors++;
        end
        advance(1);
        checks++;
        if (reset_out !== 4'b1110) begin
            $display("FAIL pwr_p22 got=%b exp=1110", reset_out);
            errors++;
        end
        advance(7);
        checks++;
        if (reset_out !== 4'b1110) begin
            $display("FAIL pwr_p29 got=%b exp=1110", reset_out);
            errors++;
        end
        advance(1);
        checks++;
        if (reset_out !== 4'b1100) begin
            $display("FAIL pwr_p30 got=%b exp=1100", reset_out);
            errors++;
        end
        advance(8);
        checks++;
        if (reset_out !== 4'b1000) begin
            $display("FAIL pwr_p38 got=%b exp=1000", reset_out);
            errors++;
        end
        advance(7);
        checks++;
        if (reset_out !== 4'b1000 || seq_done !== 1'b0) begin
            $display("FAIL pwr_p45 got=%b/%b exp=1000/0", reset_out, seq_done);
            errors++;
        end
        advance(1);
        checks++;
        if (reset_out !== 4'b0000 || seq_done !== 1'b1) begin
            $display("FAIL pwr_p46 got=%b/%b exp=0000/1", reset_out, seq_done);
            errors++;
        end
    endtask

    // ext pulse: ext_sync high P2..P3, ASSERT at P3, release P19, done P43.
    task automatic test_ext_reset();
        ext_reset = 1'b1;
        advance(1);
        ext_reset = 1'b0;
        advance(1);
        checks++;
        if (reset_out !== 4'b0000) begin
            $display("FAIL ext_p2_still_run got=%b exp=0000", reset_out);
            errors++;
        end
        advance(1);
        checks++;
        if (reset_out !== 4'b1111 || seq_done !== 1'b0) begin
            $display("FAIL ext_p3_assert got=%b/%b exp=1111/0", reset_out, seq_done);
            errors++;
        end
`ifdef RESET_SEQ_CAUSE_EN
        checks++;
        if (reset_count !== 8'd1 || reset_cause !== 3'b001) begin
            $display("FAIL ext_cause got=%0d/%b exp=1/001", reset_count, reset_cause);
            errors++;
        end
`endif
        advance(15);
        checks++;
        if (reset_out !== 4'b1111) begin
            $display("FAIL ext_p18 got=%b exp=1111", reset_out);
            errors++;
        end
        advance(1);
        checks++;
        if (reset_out !== 4'b1110) begin
            $display("FAIL ext_p19 got=%b exp=1110", reset_out);
            errors++;
        end
        advance(24);
        checks++;
        if (reset_out !== 4'b0000 || seq_done !== 1'b1) begin
            $display("FAIL ext_p43 got=%b/%b exp=0000/1", reset_out, seq_done);
            errors++;
        end
    endtask

    // sw pulse restarts; at 1100 a 1-cycle lock drop reasserts at P3,
    // lock re-filtered by P7, channel 0 released at P23.
    task automatic test_lock_glitch();
        sw_reset = 1'b1;
        advance(1);
        sw_reset = 1'b0;
        checks++;
        if (reset_out !== 4'b1111) begin
            $display("FAIL glitch_sw_assert got=%b exp=1111", reset_out);
            errors++;
        end
`ifdef RESET_SEQ_CAUSE_EN
        checks++;
        if (reset_count !== 8'd2 || reset_cause !== 3'b100) begin
            $display("FAIL glitch_sw_cause got=%0d/%b exp=2/100", reset_count, reset_cause);
            errors++;
        end
`endif
        advance(24);
        checks++;
        if (reset_out !== 4'b1100) begin
            $display("FAIL glitch_reach_1100 got=%b exp=1100", reset_out);
            errors++;
        end
        pll_locked = 1'b0;
        advance(1);
        pll_locked = 1'b1;
        advance(1);
        checks++;
        if (reset_out !== 4'b1100) begin
            $display("FAIL glitch_p2 got=%b exp=1100", reset_out);
            errors++;
        end
        advance(1);
        checks++;
        if (reset_out !== 4'b1111 || seq_done !== 1'b0) begin
            $display("FAIL glitch_p3 got=%b/%b exp=1111/0", reset_out, seq_done);
            errors++;
        end
`ifdef RESET_SEQ_CAUSE_EN
        checks++;
        if (reset_count !== 8'd3 || reset_cause !== 3'b010) begin
            $display("FAIL glitch_cause got=%0d/%b exp=3/010", reset_count, reset_cause);
            errors++;
        end
`endif
        advance(19);
        checks++;
        if (reset_out !== 4'b1111) begin
            $display("FAIL glitch_p22 got=%b exp=1111", reset_out);
            errors++;
        end
        advance(1);
        checks++;
        if (reset_out !== 4'b1110) begin
            $display("FAIL glitch_p23 got=%b exp=1110", reset_out);
            errors++;
        end
        advance(24);
        checks++;
        if (reset_out !== 4'b0000 || seq_done !== 1'b1) begin
            $display("FAIL glitch_p47 got=%b/%b exp=0000/1", reset_out, seq_done);
            errors++;
        end
    endtask

    // sw_reset raised in the one cycle where ext_sync is high: one entry.
    task automatic test_simultaneous();
        ext_reset = 1'b1;
        advance(1);
        ext_reset = 1'b0;
        advance(1);
        checks++;
        if (reset_out !== 4'b0000) begin
            $display("FAIL simul_p2_still_run got=%b exp=0000", reset_out);
            errors++;
        end
        sw_reset = 1'b1;
        advance(1);
        sw_reset = 1'b0;
        checks++;
        if (reset_out !== 4'b1111) begin
            $display("FAIL simul_p3_assert got=%b exp=1111", reset_out);
            errors++;
        end
`ifdef RESET_SEQ_CAUSE_EN
        checks++;
        if (reset_count !== 8'd4 || reset_cause !== 3'b101) begin
            $display("FAIL simul_cause got=%0d/%b exp=4/101", reset_count, reset_cause);
            errors++;
        end
        advance(1);
        checks++;
        if (reset_count !== 8'd4) begin
            $display("FAIL simul_single_entry got=%0d exp=4", reset_count);
            errors++;
        end
        advance(39);
`else
        advance(40);
`endif
        checks++;
        if (reset_out !== 4'b0000 || seq_done !== 1'b1) begin
            $display("FAIL simul_p43 got=%b/%b exp=0000/1", reset_out, seq_done);
            errors++;
        end
    endtask

    // rst_n dropped mid-STAGE between clock edges takes effect immediately.
    task automatic test_async_reset();
        sw_reset = 1'b1;
        advance(1);
        sw_reset = 1'b0;
`ifdef RESET_SEQ_CAUSE_EN
        checks++;
        if (reset_count !== 8'd5) begin
            $display("FAIL async_pre_count got=%0d exp=5", reset_count);
            errors++;
        end
`endif
        advance(20);
        checks++;
        if (reset_out !== 4'b1110) begin
            $display("FAIL async_mid_stage got=%b exp=1110", reset_out);
            errors++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (reset_out !== 4'b1111 || seq_done !== 1'b0) begin
            $display("FAIL async_immediate got=%b/%b exp=1111/0", reset_out, seq_done);
            errors++;
        end
`ifdef RESET_SEQ_CAUSE_EN
        checks++;
        if (reset_count !== 8'd0) begin
            $display("FAIL async_count got=%0d exp=0", reset_count);
            errors++;
        end
`endif
        @(negedge clk);
    endtask

    // 3 high / 1 low never gives 4 consecutive synced highs.
    task automatic test_lock_toggle();
        int bad;
        bad = 0;
        pll_locked = 1'b0;
        advance(2);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            pll_locked = ((i % 4) != 3);
            advance(1);
            if (reset_out !== 4'b1111 || seq_done !== 1'b0) begin
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL lock_toggle_held got=%0d bad cycles exp=0 (last %b/%b)", bad, reset_out, seq_done);
            errors++;
        end
        checks++;
        if (reset_out !== 4'b1111 || seq_done !== 1'b0) begin
            $display("FAIL lock_toggle_end got=%b/%b exp=1111/0", reset_out, seq_done);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_ext_reset();
        test_lock_glitch();
        test_simultaneous();
        test_async_reset();
        test_lock_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
